// File: rtl/s16x4_bus_pkg.sv
// rtl/s16x4_bus_pkg.sv - shared types and constants for the STEAMER16X4 bus responders
package s16x4_bus_pkg;

   localparam int CNT_W = 4;

   localparam logic [1:0] LANE_HI   = 2'b10;
   localparam logic [1:0] LANE_LO   = 2'b01;
   localparam logic [1:0] LANE_WORD = 2'b11;

   typedef enum logic [1:0] {
      IDLE,
      ACCESS,
      ACK
   } state_t;

   // Byte writes arrive in the low half, so mirror them onto both lanes.
   function automatic logic [15:0] steer_wdata(input logic [1:0] stb, input logic [15:0] d);
      return (stb == LANE_WORD) ? d : {d[7:0], d[7:0]};
   endfunction

endpackage

// File: rtl/s16x4_wait_timer.sv
// rtl/s16x4_wait_timer.sv - loadable wait-state down-counter shared by the bus responders
module s16x4_wait_timer
   import s16x4_bus_pkg::*;
(
   input  logic             clk_i,
   input  logic             res_i,
   input  logic             load_i,
   input  logic             clr_i,
   input  logic             dec_i,
   input  logic [CNT_W-1:0] value_i,
   output logic             done_o
);

   logic [CNT_W-1:0] cnt_q;

   always_ff @(posedge clk_i) begin
      if (res_i || clr_i) begin
         cnt_q <= '0;
      end else if (load_i) begin
         cnt_q <= value_i;
      end else if (dec_i && (cnt_q != '0)) begin
         cnt_q <= cnt_q - CNT_W'(1);
      end
   end

   assign done_o = (cnt_q == CNT_W'(1));

endmodule

// File: rtl/s16x4_sram_responder.sv
// rtl/s16x4_sram_responder.sv - STEAMER16X4 bus to asynchronous SRAM responder with fixed wait states
module s16x4_sram_responder
   import s16x4_bus_pkg::*;
#(
   parameter int WAIT_CYCLES = 3
) (
   input  logic        clk_i,
   input  logic        res_i,
   input  logic [14:0] adr_i,
   input  logic        we_i,
   input  logic        cyc_i,
   input  logic [1:0]  stb_i,
   input  logic        vda_i,
   input  logic        vpa_i,
   input  logic [15:0] dat_i,
   output logic        ack_o,
   output logic [15:0] dat_o,
   output logic [14:0] sram_a_o,
   output logic [15:0] sram_d_o,
   output logic        sram_d_oe_o,
   input  logic [15:0] sram_d_i,
   output logic        sram_ce_n_o,
   output logic        sram_oe_n_o,
   output logic        sram_we_n_o,
   output logic        sram_ub_n_o,
   output logic        sram_lb_n_o
);

   state_t      state_q;
   logic        we_q;
   logic        ack_q;
   logic [15:0] dat_q;
   logic [14:0] a_q;
   logic [15:0] d_q;
   logic        d_oe_q;
   logic        ce_n_q, oe_n_q, we_n_q, ub_n_q, lb_n_q;

   logic pending;
   logic t_load, t_clr, t_dec, t_done;
   logic unused_qual;

   assign pending     = cyc_i & (stb_i != 2'b00);
   assign unused_qual = vda_i | vpa_i;

   assign t_load = (state_q == IDLE) && pending;
   assign t_clr  = (state_q == ACCESS) && !cyc_i;
   assign t_dec  = (state_q == ACCESS);

   s16x4_wait_timer u_timer (
      .clk_i   (clk_i),
      .res_i   (res_i),
      .load_i  (t_load),
      .clr_i   (t_clr),
      .dec_i   (t_dec),
      .value_i (CNT_W'(WAIT_CYCLES)),
      .done_o  (t_done)
   );

   always_ff @(posedge clk_i) begin
      if (res_i) begin
         state_q <= IDLE;
         we_q    <= 1'b0;
         ack_q   <= 1'b0;
         dat_q   <= '0;
         a_q     <= '0;
         d_q     <= '0;
         d_oe_q  <= 1'b0;
         ce_n_q  <= 1'b1;
         oe_n_q  <= 1'b1;
         we_n_q  <= 1'b1;
         ub_n_q  <= 1'b1;
         lb_n_q  <= 1'b1;
      end else begin
         case (state_q)
            IDLE: begin
               ack_q <= 1'b0;
               if (pending) begin
                  state_q <= ACCESS;
                  we_q    <= we_i;
                  a_q     <= adr_i;
                  d_q     <= steer_wdata(stb_i, dat_i);
                  d_oe_q  <= we_i;
                  ce_n_q  <= 1'b0;
                  oe_n_q  <= we_i;
                  we_n_q  <= ~we_i;
                  ub_n_q  <= ~stb_i[1];
                  lb_n_q  <= ~stb_i[0];
               end
            end
            ACCESS: begin
               if (!cyc_i) begin
                  state_q <= IDLE;
                  d_oe_q  <= 1'b0;
                  ce_n_q  <= 1'b1;
                  oe_n_q  <= 1'b1;
                  we_n_q  <= 1'b1;
                  ub_n_q  <= 1'b1;
                  lb_n_q  <= 1'b1;
               end else if (t_done) begin
                  if (!we_q) begin
                     dat_q <= sram_d_i;
                  end
                  state_q <= ACK;
                  ack_q   <= 1'b1;
                  ce_n_q  <= 1'b1;
                  oe_n_q  <= 1'b1;
                  we_n_q  <= 1'b1;
               end
            end
            // Lanes stay enabled and write data stays driven through ACK for hold time.
            ACK: begin
               state_q <= IDLE;
               ack_q   <= 1'b0;
               d_oe_q  <= 1'b0;
               ub_n_q  <= 1'b1;
               lb_n_q  <= 1'b1;
            end
            default: begin
               state_q <= IDLE;
               ack_q   <= 1'b0;
            end
         endcase
      end
   end

   assign ack_o       = ack_q;
   assign dat_o       = dat_q;
   assign sram_a_o    = a_q;
   assign sram_d_o    = d_q;
   assign sram_d_oe_o = d_oe_q;
   assign sram_ce_n_o = ce_n_q;
   assign sram_oe_n_o = oe_n_q;
   assign sram_we_n_o = we_n_q;
   assign sram_ub_n_o = ub_n_q;
   assign sram_lb_n_o = lb_n_q;

endmodule

// File: tb/tb_s16x4_sram_responder.sv
// tb/tb_s16x4_sram_responder.sv - directed self-checking bench for s16x4_sram_responder
module tb_s16x4_sram_responder;

   logic        clk = 1'b0;
   logic        res;
   logic [14:0] adr;
   logic        we;
   logic        cyc;
   logic [1:0]  stb;
   logic [15:0] wdat;

   logic        ack3, doe3, ce3, oe3, we3, ub3, lb3;
   logic [15:0] dat3, sd3, sdi3;
   logic [14:0] a3;

   logic        ack1, unused_doe1, unused_ce1, oe1, unused_we1, unused_ub1, unused_lb1;
   logic [15:0] dat1, unused_sd1, sdi1;
   logic [14:0] a1;

   int checks = 0;
   int errors = 0;

   logic [15:0] ack_m, oe_m, we_m, doe_m, ce_m, ack1_m, oe1_m;
   logic [14:0] a_s;
   logic [15:0] d_s;
   logic        ub_s, lb_s;
   int          cap_k = 1;
   int          a10_cnt;
   int          ack_at;
   bit          second;

   always #5 clk = ~clk;

   function automatic logic [15:0] model(input logic [14:0] a);
      return (a == 15'h0123) ? 16'hA55A : {a[7:0], ~a[7:0]};
   endfunction

   always_comb sdi3 = model(a3);
   always_comb sdi1 = model(a1);

   s16x4_sram_responder #(.WAIT_CYCLES(3)) dut3 (
      .clk_i(clk), .res_i(res), .adr_i(adr), .we_i(we), .cyc_i(cyc), .stb_i(stb),
      .vda_i(1'b1), .vpa_i(1'b0), .dat_i(wdat), .ack_o(ack3), .dat_o(dat3),
      .sram_a_o(a3), .sram_d_o(sd3), .sram_d_oe_o(doe3), .sram_d_i(sdi3),
      .sram_ce_n_o(ce3), .sram_oe_n_o(oe3), .sram_we_n_o(we3),
      .sram_ub_n_o(ub3), .sram_lb_n_o(lb3)
   );

   s16x4_sram_responder #(.WAIT_CYCLES(1)) dut1 (
      .clk_i(clk), .res_i(res), .adr_i(adr), .we_i(we), .cyc_i(cyc), .stb_i(stb),
      .vda_i(1'b0), .vpa_i(1'b1), .dat_i(wdat), .ack_o(ack1), .dat_o(dat1),
      .sram_a_o(a1), .sram_d_o(unused_sd1), .sram_d_oe_o(unused_doe1), .sram_d_i(sdi1),
      .sram_ce_n_o(unused_ce1), .sram_oe_n_o(oe1), .sram_we_n_o(unused_we1),
      .sram_ub_n_o(unused_ub1), .sram_lb_n_o(unused_lb1)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic drive(input logic w, input logic [1:0] s, input logic [14:0] a, input logic [15:0] d);
      we = w; stb = s; adr = a; wdat = d; cyc = 1'b1;
   endtask

   task automatic idle_bus();
      cyc = 1'b0; stb = 2'b00; we = 1'b0;
   endtask

   task automatic clear_masks();
      ack_m = '0; oe_m = '0; we_m = '0; doe_m = '0; ce_m = '0; ack1_m = '0; oe1_m = '0;
      a10_cnt = 0;
   endtask

   task automatic sample(input int k);
      ack_m[k]  = ack3;
      oe_m[k]   = ~oe3;
      we_m[k]   = ~we3;
      doe_m[k]  = doe3;
      ce_m[k]   = ~ce3;
      ack1_m[k] = ack1;
      oe1_m[k]  = ~oe1;
      if (!ce3 && a3 == 15'h0010) a10_cnt++;
      if (k == cap_k) begin
         a_s = a3; d_s = sd3; ub_s = ub3; lb_s = lb3;
      end
   endtask

   // Issue one request at the current negedge and record 8 cycles; drop the request on ack or at drop_at.
   task automatic run(input logic w, input logic [1:0] s, input logic [14:0] a, input logic [15:0] d,
                      input bit watch1, input int drop_at, output int ack_k);
      clear_masks();
      ack_k = -1;
      drive(w, s, a, d);
      for (int k = 1; k <= 8; k++) begin
         @(negedge clk);
         sample(k);
         if (ack_k < 0 && (watch1 ? ack1 : ack3)) begin
            ack_k = k;
            idle_bus();
         end
         if (k == drop_at) idle_bus();
      end
   endtask

   initial begin
      res = 1'b1;
      idle_bus();
      adr = '0; wdat = '0;
      repeat (3) @(negedge clk);
      res = 1'b0;

      chk("reset_ack", ack3, 1'b0);
      chk("reset_dat", dat3, 16'h0000);
      chk("reset_ctrl_n", {ce3, oe3, we3, ub3, lb3}, 5'b11111);
      chk("reset_doe", doe3, 1'b0);
      chk("reset_addr_data", {a3, sd3}, 31'h0);
      @(negedge clk);

      // Word read at 0x0123
      run(1'b0, 2'b11, 15'h0123, 16'h0000, 1'b0, 0, ack_at);
      chk("rd_ack_cycle", ack_at, 4);
      chk("rd_ack_mask", ack_m, 16'h0010);
      chk("rd_oe_mask", oe_m, 16'h000E);
      chk("rd_ce_mask", ce_m, 16'h000E);
      chk("rd_we_mask", we_m, 16'h0000);
      chk("rd_addr", a_s, 15'h0123);
      chk("rd_lanes", {ub_s, lb_s}, 2'b00);
      chk("rd_data", dat3, 16'hA55A);

      // Upper byte write
      run(1'b1, 2'b10, 15'h0200, 16'h0042, 1'b0, 0, ack_at);
      chk("wr_ack_mask", ack_m, 16'h0010);
      chk("wr_sram_d", d_s, 16'h4242);
      chk("wr_lanes", {ub_s, lb_s}, 2'b01);
      chk("wr_we_mask", we_m, 16'h000E);
      chk("wr_doe_mask", doe_m, 16'h001E);
      chk("wr_oe_mask", oe_m, 16'h0000);
      chk("wr_dat_hold", dat3, 16'hA55A);

      // Back-to-back: read 0x0010 then write 0x0011 with cyc held high
      clear_masks();
      cap_k = 6;
      second = 1'b0;
      drive(1'b0, 2'b11, 15'h0010, 16'h0000);
      for (int k = 1; k <= 12; k++) begin
         @(negedge clk);
         sample(k);
         if (ack3) begin
            if (!second) begin
               drive(1'b1, 2'b01, 15'h0011, 16'h00C3);
               second = 1'b1;
            end else begin
               idle_bus();
            end
         end
      end
      cap_k = 1;
      chk("b2b_ack_mask", ack_m, 16'h0210);
      chk("b2b_ce_mask", ce_m, 16'h01CE);
      chk("b2b_addr10_cycles", a10_cnt, 3);
      chk("b2b_rd_data", dat3, 16'h10EF);
      chk("b2b_wr_sram_d", d_s, 16'hC3C3);
      chk("b2b_wr_lanes", {ub_s, lb_s}, 2'b10);

      // Abort a write by dropping cyc in cycle N+2
      run(1'b1, 2'b11, 15'h0300, 16'h1234, 1'b0, 2, ack_at);
      chk("abort_ack_mask", ack_m, 16'h0000);
      chk("abort_ce_mask", ce_m, 16'h0006);
      chk("abort_we_mask", we_m, 16'h0006);
      chk("abort_doe_mask", doe_m, 16'h0006);
      chk("abort_dat_hold", dat3, 16'h10EF);
      run(1'b0, 2'b11, 15'h0055, 16'h0000, 1'b0, 0, ack_at);
      chk("post_abort_ack_cycle", ack_at, 4);
      chk("post_abort_data", dat3, 16'h55AA);

      // Reset during ACCESS
      drive(1'b0, 2'b11, 15'h0123, 16'h0000);
      @(negedge clk);
      @(negedge clk);
      res = 1'b1;
      idle_bus();
      @(negedge clk);
      chk("midrst_ctrl_n", {ce3, oe3, we3, ub3, lb3}, 5'b11111);
      chk("midrst_ack", ack3, 1'b0);
      chk("midrst_dat", dat3, 16'h0000);
      chk("midrst_doe", doe3, 1'b0);
      res = 1'b0;
      run(1'b0, 2'b11, 15'h0055, 16'h0000, 1'b0, 0, ack_at);
      chk("post_rst_ack_cycle", ack_at, 4);
      chk("post_rst_data", dat3, 16'h55AA);

      // Minimum wait instance
      run(1'b0, 2'b11, 15'h0077, 16'h0000, 1'b1, 0, ack_at);
      chk("w1_ack_cycle", ack_at, 2);
      chk("w1_ack_mask", ack1_m, 16'h0004);
      chk("w1_oe_mask", oe1_m, 16'h0002);
      chk("w1_data", dat1, 16'h7788);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
